// File: rtl/blocks_controller_pkg.sv
// Shared constants and types for the block field: mask width, controller states
// and the all-destroyed mask shared with the renderer and collision logic.
package blocks_controller_pkg;

   localparam int N_BLOCKS = 16;
   localparam int IDX_W    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam logic [N_BLOCKS-1:0] ALL_DESTROYED = '1;

endpackage

// File: rtl/blocks_controller_if.sv
// Hit request/acknowledge bus between the two requesters and the blocks controller.
interface blocks_controller_if;
   import blocks_controller_pkg::*;

   logic [1:0]       hit_req;
   logic [IDX_W-1:0] hit_idx0;
   logic [IDX_W-1:0] hit_idx1;
   logic [1:0]       hit_ack;
   logic [1:0]       hit_valid;

   modport master (
      output hit_req, hit_idx0, hit_idx1,
      input  hit_ack, hit_valid
   );

   modport slave (
      input  hit_req, hit_idx0, hit_idx1,
      output hit_ack, hit_valid
   );

endinterface

// File: rtl/blocks_controller_rr_arbiter2.sv
// Two-way round-robin arbiter: one grant per cycle, pointer moves only on contention.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] busy,
   output logic [1:0] grant
);

   logic [1:0] eligible;
   logic       ptr;

   assign eligible = req & ~busy;

   always_comb begin
      grant = 2'b00;
      unique case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // A lone requester wins without disturbing the pointer, so fairness only shifts on a real tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= 1'b0;
      end else if (&eligible) begin
         ptr <= ~ptr;
      end
   end

endmodule

// File: rtl/blocks_controller.sv
// Owns the destroyed-block mask: arbitrates hits into a shadow mask, commits it to the
// visible mask on each vblank rising edge, and keeps score and level state.
module blocks_controller
   import blocks_controller_pkg::*;
#(
   parameter int SCORE_W = 16,
   parameter int POINTS  = 1
) (
   input  logic                pclk,
   input  logic                reset,
   input  logic                vblnk_in,
   input  logic                start,
   blocks_controller_if.slave  hit,
   output logic [N_BLOCKS-1:0] blocks_out,
   output logic [SCORE_W-1:0]  score,
   output logic                level_clear,
   output logic                playing
);

   state_t              state;
   logic [N_BLOCKS-1:0] shadow;
   logic                vblnk_d;
   logic [1:0]          grant;
   logic [IDX_W-1:0]    gnt_idx;
   logic                hit_fresh;
   logic                vblank_rise;
   logic [SCORE_W:0]    score_sum;
   logic [SCORE_W-1:0]  score_sat;

   rr_arbiter2 u_arb (
      .clk   (pclk),
      .reset (reset),
      .req   (hit.hit_req),
      .busy  (hit.hit_ack),
      .grant (grant)
   );

   assign gnt_idx     = grant[1] ? hit.hit_idx1 : hit.hit_idx0;
   assign hit_fresh   = (|grant) && (state == PLAY) && !shadow[gnt_idx];
   assign vblank_rise = vblnk_in & ~vblnk_d;
   assign score_sum   = {1'b0, score} + (SCORE_W+1)'(POINTS);
   assign score_sat   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

   // The commit copies the shadow as it stood before this cycle's hit, so a same-cycle hit waits a frame.
   always_ff @(posedge pclk) begin
      if (reset) begin
         state       <= IDLE;
         shadow      <= '0;
         blocks_out  <= '0;
         score       <= '0;
         hit.hit_ack <= 2'b00;
         hit.hit_valid <= 2'b00;
         level_clear <= 1'b0;
         playing     <= 1'b0;
         vblnk_d     <= 1'b0;
      end else begin
         vblnk_d       <= vblnk_in;
         hit.hit_ack   <= grant;
         hit.hit_valid <= hit_fresh ? grant : 2'b00;
         level_clear   <= 1'b0;

         unique case (state)
            IDLE: begin
               if (start) begin
                  state      <= PLAY;
                  playing    <= 1'b1;
                  score      <= '0;
                  shadow     <= '0;
                  blocks_out <= '0;
               end
            end
            PLAY: begin
               if (hit_fresh) begin
                  shadow[gnt_idx] <= 1'b1;
                  score           <= score_sat;
               end
               if (vblank_rise) begin
                  blocks_out <= shadow;
                  if (shadow == ALL_DESTROYED) begin
                     level_clear <= 1'b1;
                     state       <= CLEAR;
                     playing     <= 1'b0;
                  end
               end
            end
            CLEAR: begin
               if (start) begin
                  state      <= PLAY;
                  playing    <= 1'b1;
                  shadow     <= '0;
                  blocks_out <= '0;
               end
            end
            default: begin
               state   <= IDLE;
               playing <= 1'b0;
            end
         endcase
      end
   end

endmodule
